s2p_frame_controller: RTL and testbench
=======================================

// Module: s2p_frame_controller
//
// PURPOSE
//   Sequences the 15-bit serial-to-parallel shift register from the system clock domain.
//   - Synchronises the asynchronous serial_clock/serial_data pins and detects serial_clock rising edges.
//   - Drives shift/clear strobes to the datapath and counts bits into frames.
//   - Presents completed frames to the consumer with a valid/ack handshake.
//   - Aborts stalled frames on timeout and flags overruns.
//
// PARAMETERS
//   FRAME_BITS  15                Serial bits per frame; bit_count width is 4, so FRAME_BITS must be 1..15.
//   MAX_COUNT   24'd10_000_000    Idle clk cycles allowed between edges mid-frame before abort; 0 disables timeout.
//
// PORTS
//   clk           in   1  System clock; all logic on rising edge.
//   rst_n         in   1  Asynchronous active-low reset.
//   serial_clock  in   1  Async serial bit clock from pin; data sampled on its rising edge.
//   serial_data   in   1  Async serial data from pin.
//   sr_shift      out  1  One-cycle strobe: datapath shifts in sr_bit.
//   sr_bit        out  1  Bit to shift; valid while sr_shift=1.
//   sr_clear      out  1  One-cycle strobe: datapath clears to all zeros.
//   frame_valid   out  1  Completed frame held in datapath; level.
//   frame_ack     in   1  Consumer accepts frame / clears sticky errors; sampled every cycle.
//   bit_count     out  4  Bits shifted into current frame, 0..FRAME_BITS.
//   timeout_err   out  1  Sticky: a frame was aborted by timeout.
//   overrun_err   out  1  Sticky: a serial edge arrived while frame_valid=1.
//
// BEHAVIOUR
//   Reset (async assert, sync release)
//   - All outputs 0; state IDLE; timer 0.
//   - Synchroniser and edge-history flops for serial_clock reset to 1, so a line high at release gives no edge.
//   - Data synchroniser flops reset to 0.
//   Synchronisation
//   - 2-flop synchroniser per pin; edge = sync_clk & ~sync_clk_prev.
//   - sr_bit is the synchronised data registered in the edge cycle.
//   - sr_shift asserts on the clk after edge detection: 3-4 clk from pin rise.
//   - Edges spaced at least 4 clk apart must never be lost.
//   FSM states
//   - IDLE: bit_count=0, timer held at 0. Edge -> sr_shift pulse, bit_count=1, go SHIFT (or FULL if FRAME_BITS=1).
//   - SHIFT: each edge -> sr_shift pulse, bit_count+1, timer cleared.
//     - When bit_count reaches FRAME_BITS, go FULL.
//     - frame_valid=1 on the cycle after the final sr_shift.
//     - Otherwise timer increments each clk without an edge.
//   - SHIFT timeout (MAX_COUNT!=0, timer reaches MAX_COUNT-1):
//     - sr_clear pulse, bit_count=0, timeout_err=1, go IDLE.
//     - An edge in the same cycle wins: it shifts and clears the timer, no abort.
//   - FULL: frame_valid=1, bit_count=FRAME_BITS, no sr_shift.
//     - Edge -> overrun_err=1; the bit is discarded.
//     - frame_ack -> frame_valid=0 next cycle, sr_clear pulse, bit_count=0, go IDLE.
//   Priorities and corner cases
//   - frame_ack in IDLE/SHIFT: frame state unaffected.
//   - frame_ack in any state: clears timeout_err and overrun_err.
//   - Same-cycle set and ack-clear of an error flag: set wins.
//   - Edge in the same cycle as ack in FULL: discarded, overrun_err=1, no shift into the new frame.
//   - sr_shift and sr_clear are never asserted in the same cycle.
//   - Timer width is 24 bits; it saturates, never wraps.
//   - Reset mid-frame: immediate return to IDLE, no sr_clear issued; the datapath shares rst_n.
//
// TESTING
//   1. Reset release with serial_clock held 1 -> no sr_shift; all outputs 0; state IDLE.
//   2. 15 edges, data 101010101010101, 10 clk per half-period -> 15 sr_shift pulses with sr_bit matching.
//      frame_valid rises 1 clk after the 15th pulse; bit_count=15.
//   3. FRAME_BITS=15 frame completes, frame_ack=1 for 1 clk -> frame_valid=0 next cycle, one sr_clear pulse, bit_count=0.
//   4. MAX_COUNT=100: send 5 bits then stop -> 100 clk after the 5th edge, one sr_clear pulse, timeout_err=1, bit_count=0.
//      frame_ack then clears timeout_err.
//   5. Full frame unacked, 1 more edge -> overrun_err=1, no sr_shift, frame_valid stays 1.
//      Ack then 15 edges -> new frame valid.
//   6. Assert rst_n=0 after 7 bits -> bit_count=0 asynchronously.
//      Next 15 edges form a complete frame with frame_valid=1.

Source files
------------

// File: rtl/s2p_frame_controller.sv
// s2p_frame_controller
//   Sequences a serial-to-parallel shift register from the system clock
//   domain. It synchronises the serial pins, detects serial_clock rising
//   edges and strobes the datapath to shift or clear. It counts bits into
//   frames, presents completed frames with a valid/ack handshake, aborts
//   stalled frames on timeout and flags overruns.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   serial_clock in   async serial bit clock; data sampled on its rise
//   serial_data  in   async serial data
//   sr_shift     out  one-cycle strobe: datapath shifts in sr_bit
//   sr_bit       out  bit to shift, valid while sr_shift=1
//   sr_clear     out  one-cycle strobe: datapath clears to zero
//   frame_valid  out  completed frame held in datapath (level)
//   frame_ack    in   consumer accepts frame / clears sticky errors
//   bit_count    out  bits shifted into the current frame
//   timeout_err  out  sticky: a frame was aborted by timeout
//   overrun_err  out  sticky: an edge arrived while a frame was held
module s2p_frame_controller #(
    parameter int unsigned FRAME_BITS = 15,
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_clock,
    input  logic       serial_data,
    output logic       sr_shift,
    output logic       sr_bit,
    output logic       sr_clear,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic [3:0] bit_count,
    output logic       timeout_err,
    output logic       overrun_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL
    } state_t;

    localparam logic [3:0]  FRAME_LAST  = 4'(FRAME_BITS);
    localparam logic [23:0] TIMER_LIMIT = MAX_COUNT - 24'd1;

    state_t      state_q;
    logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic        sdat_s1_q, sdat_s2_q;
    logic [23:0] timer_q;
    logic        sr_shift_q, sr_bit_q, sr_clear_q, frame_valid_q;
    logic        timeout_err_q, overrun_err_q;
    logic [3:0]  bit_count_q;
    logic [3:0]  bit_count_d;
    logic        edge_det;

    assign edge_det    = sclk_s2_q & ~sclk_prev_q;
    assign bit_count_d = bit_count_q + 4'd1;

    // Clock-pin flops reset high so a line already high at release is not
    // mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q   <= 1'b1;
            sclk_s2_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            sdat_s1_q   <= 1'b0;
            sdat_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= serial_clock;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            sdat_s1_q   <= serial_data;
            sdat_s2_q   <= sdat_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            sr_shift_q    <= 1'b0;
            sr_bit_q      <= 1'b0;
            sr_clear_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            bit_count_q   <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            sr_shift_q <= 1'b0;
            sr_clear_q <= 1'b0;
            // Ack-clear comes first so a same-cycle set below overrides it.
            if (frame_ack) begin
                timeout_err_q <= 1'b0;
                overrun_err_q <= 1'b0;
            end
            case (state_q)
                IDLE, SHIFT: begin
                    if (edge_det) begin
                        // An edge beats a coincident timeout.
                        sr_shift_q  <= 1'b1;
                        sr_bit_q    <= sdat_s2_q;
                        bit_count_q <= bit_count_d;
                        timer_q     <= '0;
                        state_q     <= (bit_count_d == FRAME_LAST) ? FULL : SHIFT;
                    end else if (state_q == SHIFT && MAX_COUNT != 24'd0 &&
                                 timer_q == TIMER_LIMIT) begin
                        sr_clear_q    <= 1'b1;
                        bit_count_q   <= '0;
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= IDLE;
                    end else if (state_q == SHIFT) begin
                        if (timer_q != '1) begin
                            timer_q <= timer_q + 24'd1;
                        end
                    end else begin
                        timer_q <= '0;
                    end
                end
                FULL: begin
                    // frame_valid trails the final sr_shift by one cycle.
                    frame_valid_q <= 1'b1;
                    if (edge_det) begin
                        overrun_err_q <= 1'b1;
                    end
                    if (frame_ack) begin
                        frame_valid_q <= 1'b0;
                        sr_clear_q    <= 1'b1;
                        bit_count_q   <= '0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sr_shift    = sr_shift_q;
    assign sr_bit      = sr_bit_q;
    assign sr_clear    = sr_clear_q;
    assign frame_valid = frame_valid_q;
    assign bit_count   = bit_count_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_s2p_frame_controller.sv
// tb_s2p_frame_controller
//   Drives serial bit streams into s2p_frame_controller and compares its
//   strobes, counters and flags against a frame-level reference model.
module tb_s2p_frame_controller;

    localparam int unsigned FB   = 15;
    localparam logic [23:0] MAXC = 24'd100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_clock = 1'b1;
    logic       serial_data = 1'b0;
    logic       frame_ack = 1'b0;
    logic       sr_shift, sr_bit, sr_clear, frame_valid;
    logic [3:0] bit_count;
    logic       timeout_err, overrun_err;

    always #5 clk = ~clk;

    s2p_frame_controller #(
        .FRAME_BITS(FB),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_clock(serial_clock),
        .serial_data (serial_data),
        .sr_shift    (sr_shift),
        .sr_bit      (sr_bit),
        .sr_clear    (sr_clear),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .bit_count   (bit_count),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame contents and flags in terms of serial edges.
    logic exp_q[$];
    int   m_count = 0;
    bit   m_full = 0, m_ovr = 0, m_to = 0;
    int   m_clear = 0;
    int   since_rise = 0;

    // Monitor bookkeeping (sampled on the falling edge).
    int   cyc = 0, n_shift = 0, n_clear = 0;
    int   last_shift_cyc = 0, last_clear_cyc = 0, fv_rise_cyc = 0;
    logic fv_prev = 1'b0;

    always @(negedge clk) begin
        logic e;
        cyc = cyc + 1;
        if (sr_shift) begin
            n_shift = n_shift + 1;
            last_shift_cyc = cyc;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL shift_unexpected: got sr_shift bit=%0b, expected no shift", sr_bit);
            end else begin
                e = exp_q.pop_front();
                if (sr_bit !== e) begin
                    errors = errors + 1;
                    $display("FAIL sr_bit: got %0b expected %0b", sr_bit, e);
                end
            end
        end
        if (sr_clear) begin
            n_clear = n_clear + 1;
            last_clear_cyc = cyc;
        end
        if (sr_shift || sr_clear) begin
            checks = checks + 1;
            if (sr_shift && sr_clear) begin
                errors = errors + 1;
                $display("FAIL strobe_overlap: got shift=1 clear=1, expected at most one");
            end
        end
        if (frame_valid && !fv_prev) fv_rise_cyc = cyc;
        fv_prev = frame_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        since_rise = since_rise + n;
    endtask

    // A frame in progress is aborted once the pin-rise gap exceeds MAXC clocks.
    task automatic model_timeout_check();
        if (m_count != 0 && !m_full && MAXC != 24'd0 && since_rise > int'(MAXC)) begin
            m_count = 0;
            m_to    = 1;
            m_clear = m_clear + 1;
        end
    endtask

    task automatic model_edge(input logic b);
        model_timeout_check();
        since_rise = 0;
        if (m_full) begin
            m_ovr = 1;
        end else begin
            exp_q.push_back(b);
            m_count = m_count + 1;
            if (m_count == int'(FB)) m_full = 1;
        end
    endtask

    task automatic model_ack();
        m_ovr = 0;
        m_to  = 0;
        if (m_full) begin
            m_full  = 0;
            m_count = 0;
            m_clear = m_clear + 1;
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_full = 0; m_ovr = 0; m_to = 0;
        since_rise = 0;
        exp_q.delete();
    endtask

    // One serial bit: clock low for lo clocks (optional ack pulse at its
    // start), then high for hi clocks.
    task automatic send_bit(input logic b, input int lo, input int hi, input bit ack);
        serial_clock = 1'b0;
        serial_data  = b;
        if (ack) begin
            frame_ack = 1'b1;
            tick(1);
            frame_ack = 1'b0;
            model_ack();
            tick(lo - 1);
        end else begin
            tick(lo);
        end
        model_edge(b);
        serial_clock = 1'b1;
        tick(hi);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        model_ack();
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        serial_clock = 1'b1;
        serial_data = 1'($urandom_range(0, 1));
        tick(3);
        rst_n = 1'b1;
        tick(6);
        checks = checks + 3;
        if ({sr_shift, sr_clear, frame_valid} !== 3'b000) begin
            errors = errors + 1;
            $display("FAIL reset_strobes: got shift/clear/valid=%b expected 000", {sr_shift, sr_clear, frame_valid});
        end
        if ({bit_count, timeout_err, overrun_err, sr_bit} !== 7'd0) begin
            errors = errors + 1;
            $display("FAIL reset_state: got count=%0d to=%0b ov=%0b bit=%0b expected all 0", bit_count, timeout_err, overrun_err, sr_bit);
        end
        if (n_shift !== 0) begin
            errors = errors + 1;
            $display("FAIL reset_no_edge: got %0d shifts expected 0", n_shift);
        end
    endtask

    task automatic test_frame();
        logic [14:0] pat;
        pat = 15'b101010101010101;
        for (int i = 14; i >= 0; i--) begin
            send_bit(pat[i], 10, 10, 0);
            checks = checks + 2;
            if (bit_count !== 4'(m_count)) begin
                errors = errors + 1;
                $display("FAIL frame_count: got %0d expected %0d", bit_count, m_count);
            end
            if (frame_valid !== m_full) begin
                errors = errors + 1;
                $display("FAIL frame_valid: got %0b expected %0b after %0d bits", frame_valid, m_full, m_count);
            end
        end
        checks = checks + 1;
        if (fv_rise_cyc !== last_shift_cyc + 1) begin
            errors = errors + 1;
            $display("FAIL valid_latency: got rise at %0d expected %0d", fv_rise_cyc, last_shift_cyc + 1);
        end
    endtask

    task automatic test_ack();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        model_ack();
        checks = checks + 1;
        if ({frame_valid, sr_clear, bit_count} !== {1'b0, 1'b1, 4'd0}) begin
            errors = errors + 1;
            $display("FAIL ack_response: got valid=%0b clear=%0b count=%0d expected 0 1 0", frame_valid, sr_clear, bit_count);
        end
        tick(1);
        checks = checks + 1;
        if (sr_clear !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ack_clear_pulse: got clear=%0b on 2nd cycle expected 0", sr_clear);
        end
        tick(2);
        checks = checks + 1;
        if (n_clear !== m_clear) begin
            errors = errors + 1;
            $display("FAIL ack_clear_count: got %0d expected %0d", n_clear, m_clear);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 10, 10, 0);
        tick(150);
        model_timeout_check();
        checks = checks + 4;
        if (last_clear_cyc - last_shift_cyc !== int'(MAXC)) begin
            errors = errors + 1;
            $display("FAIL timeout_latency: got %0d expected %0d", last_clear_cyc - last_shift_cyc, int'(MAXC));
        end
        if (timeout_err !== m_to) begin
            errors = errors + 1;
            $display("FAIL timeout_err: got %0b expected %0b", timeout_err, m_to);
        end
        if (bit_count !== 4'(m_count)) begin
            errors = errors + 1;
            $display("FAIL timeout_count: got %0d expected %0d", bit_count, m_count);
        end
        if (n_clear !== m_clear) begin
            errors = errors + 1;
            $display("FAIL timeout_clears: got %0d expected %0d", n_clear, m_clear);
        end
        do_ack();
        checks = checks + 1;
        if (timeout_err !== m_to) begin
            errors = errors + 1;
            $display("FAIL timeout_ack_clear: got %0b expected %0b", timeout_err, m_to);
        end
    endtask

    task automatic test_timeout_boundary();
        send_bit(1'($urandom_range(0, 1)), 10, 10, 0);
        send_bit(1'($urandom_range(0, 1)), 90, 10, 0);  // gap of exactly MAXC
        checks = checks + 2;
        if (bit_count !== 4'(m_count) || timeout_err !== m_to) begin
            errors = errors + 1;
            $display("FAIL gap_limit: got count=%0d to=%0b expected %0d %0b", bit_count, timeout_err, m_count, m_to);
        end
        if (n_clear !== m_clear) begin
            errors = errors + 1;
            $display("FAIL gap_limit_clears: got %0d expected %0d", n_clear, m_clear);
        end
        send_bit(1'($urandom_range(0, 1)), 91, 10, 0);  // gap of MAXC+1
        checks = checks + 2;
        if (bit_count !== 4'(m_count) || timeout_err !== m_to) begin
            errors = errors + 1;
            $display("FAIL gap_over: got count=%0d to=%0b expected %0d %0b", bit_count, timeout_err, m_count, m_to);
        end
        if (n_clear !== m_clear) begin
            errors = errors + 1;
            $display("FAIL gap_over_clears: got %0d expected %0d", n_clear, m_clear);
        end
        tick(150);
        model_timeout_check();
        do_ack();
        checks = checks + 1;
        if (bit_count !== 4'(m_count) || timeout_err !== m_to) begin
            errors = errors + 1;
            $display("FAIL gap_recover: got count=%0d to=%0b expected %0d %0b", bit_count, timeout_err, m_count, m_to);
        end
    endtask

    task automatic test_overrun();
        int shifts_before;
        for (int i = 0; i < int'(FB); i++) send_bit(1'($urandom_range(0, 1)), 10, 10, 0);
        shifts_before = n_shift;
        send_bit(1'($urandom_range(0, 1)), 10, 10, 0);
        checks = checks + 2;
        if ({overrun_err, frame_valid, bit_count} !== {m_ovr, m_full, 4'(m_count)}) begin
            errors = errors + 1;
            $display("FAIL overrun_state: got ov=%0b valid=%0b count=%0d expected %0b %0b %0d", overrun_err, frame_valid, bit_count, m_ovr, m_full, m_count);
        end
        if (n_shift !== shifts_before) begin
            errors = errors + 1;
            $display("FAIL overrun_shift: got %0d shifts expected %0d", n_shift, shifts_before);
        end
        do_ack();
        checks = checks + 1;
        if ({overrun_err, frame_valid} !== {m_ovr, m_full}) begin
            errors = errors + 1;
            $display("FAIL overrun_ack: got ov=%0b valid=%0b expected %0b %0b", overrun_err, frame_valid, m_ovr, m_full);
        end
        for (int i = 0; i < int'(FB); i++) send_bit(1'($urandom_range(0, 1)), 5, 5, 0);
        checks = checks + 1;
        if ({frame_valid, bit_count} !== {m_full, 4'(m_count)}) begin
            errors = errors + 1;
            $display("FAIL overrun_next_frame: got valid=%0b count=%0d expected %0b %0d", frame_valid, bit_count, m_full, m_count);
        end
        do_ack();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 8, 8, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks = checks + 1;
        if (bit_count !== 4'(m_count)) begin
            errors = errors + 1;
            $display("FAIL async_reset_count: got %0d expected %0d", bit_count, m_count);
        end
        tick(3);
        rst_n = 1'b1;
        tick(3);
        for (int i = 0; i < int'(FB); i++) send_bit(1'($urandom_range(0, 1)), 6, 6, 0);
        checks = checks + 2;
        if ({frame_valid, bit_count} !== {m_full, 4'(m_count)}) begin
            errors = errors + 1;
            $display("FAIL post_reset_frame: got valid=%0b count=%0d expected %0b %0d", frame_valid, bit_count, m_full, m_count);
        end
        if (n_clear !== m_clear) begin
            errors = errors + 1;
            $display("FAIL reset_no_clear: got %0d clears expected %0d", n_clear, m_clear);
        end
        do_ack();
    endtask

    task automatic test_random();
        for (int i = 1; i <= 80; i++) begin
            send_bit(1'($urandom_range(0, 1)), int'($urandom_range(4, 12)),
                     int'($urandom_range(4, 12)), ($urandom_range(0, 3) == 0));
            if (i % 10 == 0) begin
                checks = checks + 1;
                if ({bit_count, frame_valid, overrun_err, timeout_err} !==
                    {4'(m_count), m_full, m_ovr, m_to}) begin
                    errors = errors + 1;
                    $display("FAIL random_state[%0d]: got count=%0d valid=%0b ov=%0b to=%0b expected %0d %0b %0b %0b",
                             i, bit_count, frame_valid, overrun_err, timeout_err, m_count, m_full, m_ovr, m_to);
                end
            end
        end
    endtask

    task automatic test_end();
        do_ack();
        tick(3);
        checks = checks + 2;
        if (exp_q.size() !== 0) begin
            errors = errors + 1;
            $display("FAIL pending_shifts: got %0d unshifted bits expected 0", exp_q.size());
        end
        if (n_clear !== m_clear) begin
            errors = errors + 1;
            $display("FAIL total_clears: got %0d expected %0d", n_clear, m_clear);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ack();
        test_timeout();
        test_timeout_boundary();
        test_overrun();
        test_reset_midframe();
        test_random();
        test_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
